spi_cmd_ctrl: RTL
=================

# spi_cmd_ctrl

Command sequencer between the 24-bit SPI slave and the WS2812 pixel datapath. Consumes each received word (`mosi_rx` strobe plus `mosi_data_out`), decodes it, writes pixel bursts into the pixel RAM, and configures the LED count. It also schedules refresh starts against the WS2812 driver's busy flag and queues 24-bit status replies onto the slave's MISO path.

## Interface
Parameters:
- `PIX_AW`, 8: pixel RAM address width (2^PIX_AW LEDs max).
- `TIMEOUT`, 24'd1_000_000: `clk_sb` cycles allowed between data words of a burst before abort.

Ports:
- `clk_sb` in 1: system clock, same clock as the SPI slave.
- `reset_n` in 1: asynchronous, active-low reset.
- `mosi_rx` in 1: one-cycle strobe, word received.
- `mosi_data_out` in 24: received word, valid when `mosi_rx`=1.
- `miso_tx` out 1: one-cycle strobe, load reply.
- `miso_data_in` out 24: reply word, stable from `miso_tx` until next `miso_tx`.
- `pix_we` out 1: pixel RAM write enable.
- `pix_addr` out PIX_AW: pixel RAM write address.
- `pix_wdata` out 24: GRB pixel data.
- `num_leds` out 16: configured chain length.
- `show_start` out 1: one-cycle refresh request to the driver.
- `drv_busy` in 1: driver is shifting out a frame.

## Operation
- Opcode is word[23:20] in the CMD phase only. Data-phase words are raw GRB.
- 0x0 NOP: no action.
- 0x1 WRITE_BURST: start = word[PIX_AW-1:0] of field [15:8] (`PIX_AW` ≤ 8), count = word[7:0]+1 (1..256). Enters DATA. The next `count` words are each written to `pix_addr`, and the address increments modulo 2^PIX_AW (wrap allowed).
- 0x2 SHOW: refresh request. If `drv_busy`=0 and none is pending, `show_start` pulses. Otherwise `pending` is set; multiple SHOWs collapse into one.
- 0x3 SET_LEN: `num_leds` <= word[15:0].
- 0x4 STATUS: `miso_data_in` <= {8'hA5, pending, drv_busy, burst_active, 5'b0, err_cnt[7:0]}, then `miso_tx` pulses.
- Other opcodes: ignored, `err_cnt`++.
- `err_cnt` is 8 bits and saturates at 8'hFF; it is cleared only by reset.
- FSM states:
  - IDLE → CMD on reset release.
  - CMD: WRITE_BURST → DATA; every other opcode stays in CMD.
  - DATA: on the last data word → CMD. On timeout → CMD with `err_cnt`++; the partial burst stays written.
- Timeout counter: cleared on entry to DATA and on each data word. Increments each cycle in DATA. It fires when it reaches `TIMEOUT`-1 with no `mosi_rx`.

## Timing
- Reset values:
  - `miso_tx`=0, `miso_data_in`=0, `pix_we`=0, `pix_addr`=0, `pix_wdata`=0.
  - `num_leds`=16'd0, `show_start`=0.
  - `pending`=0, `err_cnt`=0, state=IDLE.
- All outputs are registered.
- Latencies, from `mosi_rx` in cycle N:
  - `pix_we`/`pix_addr`/`pix_wdata` valid in cycle N+1, `pix_we` high exactly one cycle.
  - `num_leds` updates at N+1.
  - `miso_tx` pulses at N+1.
- `show_start`:
  - Immediate case: pulses at N+1.
  - Pending case: pulses one cycle after the first cycle `drv_busy` is sampled 0; `pending` clears that same cycle.
- A SHOW arriving in the same cycle a pending pulse issues is absorbed, with no second pulse.
- Timeout and `mosi_rx` in the same cycle: the word wins and is written as data.
- Reset asserted mid-burst or mid-pending: everything returns to reset values immediately, and no `show_start` is emitted.
- `mosi_rx` strobes are at least 24 SPI clocks apart; the block needs no back-pressure.

## Structure
- Shared package `ws_spi_pkg`:
  - Opcode localparams (`OP_NOP`, `OP_WRITE_BURST`, `OP_SHOW`, `OP_SET_LEN`, `OP_STATUS`).
  - `STATUS_MAGIC` = 8'hA5.
  - FSM state encoding.
- Sub-module `spi_show_sched` holds the `pending`/`drv_busy`/`show_start` handshake. Inputs are `clk_sb`, `reset_n`, `req`, `drv_busy`; outputs are `show_start`, `pending`.
- Top level holds the decoder, FSM, burst address counter, timeout counter and error counter.

## Test plan
- Burst write: word 24'h1_0_FE_02, then 24'h112233, 24'h445566, 24'h778899 → three `pix_we` pulses at addr 0xFE, 0xFF, 0x00 with those data; state back to CMD.
- Show scheduling:
  - SHOW with `drv_busy`=0 → `show_start` one cycle after `mosi_rx`.
  - SHOW twice with `drv_busy`=1, then `drv_busy` falls → exactly one `show_start`, one cycle after the fall.
- SET_LEN then STATUS: word 24'h3_0_012C → `num_leds`=300. Then 24'h4_00000 with `drv_busy`=0 → `miso_tx` pulse, `miso_data_in`=24'hA50000.
- Timeout: `TIMEOUT`=100, WRITE_BURST with count 4, send 1 data word then idle 100 cycles → one write only, `err_cnt`=1. A next word 24'h000000 is decoded as NOP (no write).
- Error and reset:
  - Opcode 0xF sent 300 times → `err_cnt` saturates at 8'hFF.
  - `reset_n` low mid-burst with `pending`=1 → all outputs 0 immediately; no `show_start` after release.

Source files
------------

// File: rtl/ws_spi_pkg.sv
// Shared definitions for the SPI command path feeding the WS2812 pixel datapath.
// Holds opcode values, the status reply magic byte, the sequencer state encoding
// and a saturating counter helper.
package ws_spi_pkg;

  localparam logic [3:0] OP_NOP         = 4'h0;
  localparam logic [3:0] OP_WRITE_BURST = 4'h1;
  localparam logic [3:0] OP_SHOW        = 4'h2;
  localparam logic [3:0] OP_SET_LEN     = 4'h3;
  localparam logic [3:0] OP_STATUS      = 4'h4;

  localparam logic [7:0] STATUS_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_show_sched.sv
// Refresh scheduler: turns SHOW requests into one show_start pulse per idle window of the driver.
// Latency: immediate request -> show_start next cycle; pending -> one cycle after drv_busy seen low.
// Backpressure: none; requests arriving while one is pending or issuing are merged into it.
module spi_show_sched (
  input  logic clk_sb,
  input  logic reset_n,
  input  logic req,
  input  logic drv_busy,
  output logic show_start,
  output logic pending
);

  logic r_show_start;
  logic r_pending;

  // Issue a refresh now if the driver is free, otherwise remember one and fire when it frees up.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_show_start <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_show_start <= 1'b0;
      if (r_pending) begin
        // Any request seen here is absorbed into the pulse about to issue.
        if (!drv_busy) begin
          r_show_start <= 1'b1;
          r_pending    <= 1'b0;
        end
      end else if (req && !r_show_start) begin
        if (drv_busy) begin
          r_pending <= 1'b1;
        end else begin
          r_show_start <= 1'b1;
        end
      end
    end
  end

  assign show_start = r_show_start;
  assign pending    = r_pending;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: decodes SPI words into pixel bursts, length config, refresh and status replies.
// Latency: every output reacts one cycle after the mosi_rx strobe (refresh may wait on drv_busy).
// Backpressure: none; words arrive far apart, a stalled burst is abandoned after TIMEOUT cycles.
module spi_cmd_ctrl #(
  parameter int          PIX_AW  = 8,
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic              clk_sb,
  input  logic              reset_n,
  input  logic              mosi_rx,
  input  logic [23:0]       mosi_data_out,
  output logic              miso_tx,
  output logic [23:0]       miso_data_in,
  output logic              pix_we,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [23:0]       pix_wdata,
  output logic [15:0]       num_leds,
  output logic              show_start,
  input  logic              drv_busy
);

  import ws_spi_pkg::*;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PIX_AW-1:0]   r_burst_addr;
  logic [7:0]          r_remain;
  logic [23:0]         r_tmo_cnt;
  logic [7:0]          r_err_cnt;
  logic                r_pix_we;
  logic [PIX_AW-1:0]   r_pix_addr;
  logic [23:0]         r_pix_wdata;
  logic [15:0]         r_num_leds;
  logic                r_miso_tx;
  logic [23:0]         r_miso_data;

  logic [3:0]          w_op;
  logic                w_cmd_vld;
  logic                w_data_vld;
  logic                w_burst_start;
  logic                w_last_word;
  logic                w_timeout;
  logic                w_show_req;
  logic                w_bad_op;
  logic                w_burst_active;
  logic                w_pending;

  // Opcode only has meaning for words taken in the command phase.
  assign w_op           = mosi_data_out[23:20];
  assign w_cmd_vld      = mosi_rx && (r_state == ST_CMD);
  assign w_data_vld     = mosi_rx && (r_state == ST_DATA);
  assign w_burst_start  = w_cmd_vld && (w_op == OP_WRITE_BURST);
  assign w_last_word    = w_data_vld && (r_remain == 8'd0);
  assign w_show_req     = w_cmd_vld && (w_op == OP_SHOW);
  assign w_bad_op       = w_cmd_vld && (w_op > OP_STATUS);
  assign w_burst_active = (r_state == ST_DATA);
  // A word landing on the expiry cycle still counts as data.
  assign w_timeout      = (r_state == ST_DATA) && !mosi_rx && (r_tmo_cnt == TIMEOUT - 24'd1);

  // Sequencer state register.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next state: bursts enter DATA, leave on last word or on stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_CMD;
      ST_CMD:  if (w_burst_start) w_state_nxt = ST_DATA;
      ST_DATA: if (w_last_word || w_timeout) w_state_nxt = ST_CMD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: running pixel address and words still owed.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_addr <= '0;
      r_remain     <= 8'd0;
    end else if (w_burst_start) begin
      r_burst_addr <= mosi_data_out[8 +: PIX_AW];
      r_remain     <= mosi_data_out[7:0];
    end else if (w_data_vld) begin
      r_burst_addr <= r_burst_addr + PIX_AW'(1);
      r_remain     <= r_remain - 8'd1;
    end
  end

  // Stall detector: restarts on burst entry and on every data word.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= 24'd0;
    end else if (w_burst_start || w_data_vld || (r_state != ST_DATA)) begin
      r_tmo_cnt <= 24'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
  end

  // Error tally for unknown opcodes and abandoned bursts; held at 0xFF once full.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_bad_op || w_timeout) begin
      r_err_cnt <= sat_inc8(r_err_cnt);
    end
  end

  // Pixel RAM write port: one-cycle strobe per data word, address/data held afterwards.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_we    <= 1'b0;
      r_pix_addr  <= '0;
      r_pix_wdata <= 24'd0;
    end else begin
      r_pix_we <= 1'b0;
      if (w_data_vld) begin
        r_pix_we    <= 1'b1;
        r_pix_addr  <= r_burst_addr;
        r_pix_wdata <= mosi_data_out;
      end
    end
  end

  // Configuration and status reply registers.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_num_leds  <= 16'd0;
      r_miso_tx   <= 1'b0;
      r_miso_data <= 24'd0;
    end else begin
      r_miso_tx <= 1'b0;
      if (w_cmd_vld && (w_op == OP_SET_LEN)) begin
        r_num_leds <= mosi_data_out[15:0];
      end
      if (w_cmd_vld && (w_op == OP_STATUS)) begin
        r_miso_tx   <= 1'b1;
        r_miso_data <= {STATUS_MAGIC, w_pending, drv_busy, w_burst_active, 5'b0, r_err_cnt};
      end
    end
  end

  spi_show_sched u_show_sched (
    .clk_sb     (clk_sb),
    .reset_n    (reset_n),
    .req        (w_show_req),
    .drv_busy   (drv_busy),
    .show_start (show_start),
    .pending    (w_pending)
  );

  assign pix_we       = r_pix_we;
  assign pix_addr     = r_pix_addr;
  assign pix_wdata    = r_pix_wdata;
  assign num_leds     = r_num_leds;
  assign miso_tx      = r_miso_tx;
  assign miso_data_in = r_miso_data;

endmodule
